// File: rtl/deser_stack_pkg.sv
// Shared types for the deserializer-to-stack controller: FSM state encoding
// and the default data width.
package deser_stack_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CAPTURE,
        S_PUSH,
        S_ACK_WAIT,
        S_POP,
        S_POP_WAIT
    } state_t;

endpackage

// File: rtl/deser_stack_ctrl_sync_bit.sv
// Multi-flop level synchronizer, reset to 0. Fewer than two stages is
// promoted to two so the output is always at least double-registered.
module sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    localparam int unsigned N = (STAGES < 2) ? 2 : STAGES;

    logic [N-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N-2:0], d_i};
        end
    end

    assign q_o = sync_q[N-1];

endmodule

// File: rtl/deser_stack_ctrl.sv
// Deserializer-to-LIFO controller: 4-phase ready/ack push path, pop service,
// single-port arbitration. Optional drop-on-full: DESER_STACK_DROP_ON_FULL_EN.
module deser_stack_ctrl
    import deser_stack_pkg::*;
#(
    parameter int unsigned WIDTH       = WIDTH_DEFAULT,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] des_data,
    input  logic             des_ready,
    output logic             des_ack,
    output logic             stk_push,
    output logic             stk_pop,
    output logic [WIDTH-1:0] stk_wdata,
    input  logic [WIDTH-1:0] stk_rdata,
    input  logic             stk_full,
    input  logic             stk_empty,
    input  logic             pop_req,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic             busy,
    output logic [CNT_W-1:0] drop_count
);

    state_t           state_q, state_d;
    logic             rdy_s;
    logic             des_ack_q, stk_push_q, stk_pop_q, pop_valid_q, busy_q;
    logic [WIDTH-1:0] stk_wdata_q, pop_data_q;

    sync_bit #(.STAGES(SYNC_STAGES)) u_sync_ready (
        .clk   (clk),
        .reset (reset),
        .d_i   (des_ready),
        .q_o   (rdy_s)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (pop_req && !stk_empty) begin
                    state_d = S_POP;
                end else if (rdy_s && !stk_full) begin
                    state_d = S_CAPTURE;
`ifdef DESER_STACK_DROP_ON_FULL_EN
                end else if (rdy_s && stk_full) begin
                    state_d = S_ACK_WAIT;
`endif
                end
            end
            S_CAPTURE:  state_d = S_PUSH;
            S_PUSH:     state_d = S_ACK_WAIT;
            S_ACK_WAIT: if (!rdy_s) state_d = S_IDLE;
            S_POP:      state_d = S_POP_WAIT;
            S_POP_WAIT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Strobes/levels are decoded from state_d so each output is a flop that is
    // high exactly while the FSM sits in the matching state. stk_wdata_q doubles
    // as the hold register: loaded in CAPTURE, presented during PUSH only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            des_ack_q   <= 1'b0;
            stk_push_q  <= 1'b0;
            stk_pop_q   <= 1'b0;
            stk_wdata_q <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            des_ack_q   <= (state_d == S_ACK_WAIT);
            stk_push_q  <= (state_d == S_PUSH);
            stk_pop_q   <= (state_d == S_POP);
            busy_q      <= (state_d != S_IDLE);
            pop_valid_q <= (state_q == S_POP_WAIT);
            stk_wdata_q <= (state_q == S_CAPTURE) ? des_data : '0;
            if (state_q == S_POP_WAIT) begin
                pop_data_q <= stk_rdata;
            end
        end
    end

`ifdef DESER_STACK_DROP_ON_FULL_EN
    logic [CNT_W-1:0] drop_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (state_q == S_IDLE && state_d == S_ACK_WAIT && drop_cnt_q != '1) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = '0;
`endif

    assign des_ack   = des_ack_q;
    assign stk_push  = stk_push_q;
    assign stk_pop   = stk_pop_q;
    assign stk_wdata = stk_wdata_q;
    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_deser_stack_ctrl.sv
// Bench for deser_stack_ctrl: directed handshake/latency steps followed by a
// randomized push/pop mix checked against a LIFO reference queue.
module tb_deser_stack_ctrl;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] des_data;
    logic       des_ready;
    logic       des_ack;
    logic       stk_push, stk_pop;
    logic [7:0] stk_wdata;
    logic [7:0] stk_rdata = 8'h00;
    logic       stk_full, stk_empty;
    logic       pop_req;
    logic [7:0] pop_data;
    logic       pop_valid, busy;
    logic [7:0] drop_count;

    int         n_vec = 0;
    int         n_err = 0;

    logic [7:0] mem[$];
    int         msize = 0;
    int         push_cnt = 0;
    logic [7:0] last_push = 8'h00;
    bit         force_full = 1'b0;

    logic [7:0] ref_q[$];

    deser_stack_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .des_data   (des_data),
        .des_ready  (des_ready),
        .des_ack    (des_ack),
        .stk_push   (stk_push),
        .stk_pop    (stk_pop),
        .stk_wdata  (stk_wdata),
        .stk_rdata  (stk_rdata),
        .stk_full   (stk_full),
        .stk_empty  (stk_empty),
        .pop_req    (pop_req),
        .pop_data   (pop_data),
        .pop_valid  (pop_valid),
        .busy       (busy),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    assign stk_empty = (msize == 0);
    assign stk_full  = force_full || (msize >= DEPTH);

    // Behavioural LIFO standing in for the stack; pop data appears before the
    // edge that closes the cycle following stk_pop.
    always @(negedge clk) begin
        if (stk_push) begin
            mem.push_back(stk_wdata);
            push_cnt++;
            last_push = stk_wdata;
        end
        if (stk_pop && mem.size() > 0) begin
            stk_rdata <= mem.pop_back();
        end
        msize = mem.size();
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        chk("push_pop_excl", {31'b0, stk_push & stk_pop}, 32'd0);
    endtask

    // Finish a 4-phase handshake already started by raising des_ready.
    task automatic complete_hs();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            tick();
            if (des_ack === 1'b1) ok = 1'b1;
        end
        chk("ack_rise", {31'b0, ok}, 32'd1);
        des_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            if (des_ack === 1'b0) ok = 1'b1;
        end
        chk("ack_fall", {31'b0, ok}, 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        des_data  = b;
        des_ready = 1'b1;
        complete_hs();
    endtask

    task automatic do_pop(output logic [7:0] d, output bit got);
        got = 1'b0;
        d   = 8'h00;
        pop_req = 1'b1;
        tick();
        pop_req = 1'b0;
        for (int i = 0; i < 6 && !got; i++) begin
            tick();
            if (pop_valid === 1'b1) begin
                got = 1'b1;
                d   = pop_data;
            end
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] b;
        bit         got;
        int         pc0;
        int         exp_drops;

        exp_drops = 0;
        reset     = 1'b1;
        des_data  = 8'h00;
        des_ready = 1'b0;
        pop_req   = 1'b0;
        tick();
        tick();
        chk("rst_des_ack",   {31'b0, des_ack},   32'd0);
        chk("rst_stk_push",  {31'b0, stk_push},  32'd0);
        chk("rst_stk_pop",   {31'b0, stk_pop},   32'd0);
        chk("rst_stk_wdata", {24'b0, stk_wdata}, 32'd0);
        chk("rst_pop_data",  {24'b0, pop_data},  32'd0);
        chk("rst_pop_valid", {31'b0, pop_valid}, 32'd0);
        chk("rst_busy",      {31'b0, busy},      32'd0);
        chk("rst_drop",      {24'b0, drop_count}, 32'd0);
        reset = 1'b0;
        tick();

        // Push path: strobe exactly SYNC_STAGES+2 edges after des_ready rises.
        des_data  = 8'hA5;
        des_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk($sformatf("push_lat_%0d", k), {31'b0, stk_push}, (k == 4) ? 32'd1 : 32'd0);
        end
        chk("push_wdata", {24'b0, stk_wdata}, 32'hA5);
        chk("push_busy",  {31'b0, busy},      32'd1);
        complete_hs();
        ref_q.push_back(8'hA5);
        chk("push_once", push_cnt, 32'd1);

        // Pop path with exact latency.
        send_byte(8'h3C);
        ref_q.push_back(8'h3C);
        pop_req = 1'b1;
        tick();
        chk("pop_strobe", {31'b0, stk_pop}, 32'd1);
        pop_req = 1'b0;
        tick();
        chk("pop_strobe_off", {31'b0, stk_pop},   32'd0);
        chk("pop_valid_early", {31'b0, pop_valid}, 32'd0);
        tick();
        chk("pop_valid", {31'b0, pop_valid}, 32'd1);
        chk("pop_data",  {24'b0, pop_data},  32'h3C);
        void'(ref_q.pop_back());
        tick();
        chk("pop_valid_once", {31'b0, pop_valid}, 32'd0);

`ifndef DESER_STACK_DROP_ON_FULL_EN
        // Simultaneous: hold rdy_s back with full, then release it together with a pop.
        force_full = 1'b1;
        des_data   = 8'h77;
        des_ready  = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        chk("sim_no_ack", {31'b0, des_ack}, 32'd0);
        force_full = 1'b0;
        pop_req    = 1'b1;
        tick();
        chk("sim_pop_first", {31'b0, stk_pop}, 32'd1);
        pop_req = 1'b0;
        tick();
        tick();
        chk("sim_pop_valid", {31'b0, pop_valid}, 32'd1);
        chk("sim_pop_data",  {24'b0, pop_data},  {24'b0, ref_q.pop_back()});
        tick();
        chk("sim_push_wait", {31'b0, stk_push}, 32'd0);
        tick();
        chk("sim_push",       {31'b0, stk_push},  32'd1);
        chk("sim_push_wdata", {24'b0, stk_wdata}, 32'h77);
        complete_hs();
        ref_q.push_back(8'h77);

        // Full stall: no ack, no push while full; push resumes when it clears.
        pc0        = push_cnt;
        force_full = 1'b1;
        des_data   = 8'h5A;
        des_ready  = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("stall_no_ack", {31'b0, des_ack}, 32'd0);
        end
        chk("stall_no_push", push_cnt, pc0);
        force_full = 1'b0;
        complete_hs();
        chk("stall_push_cnt",  push_cnt,            pc0 + 1);
        chk("stall_push_data", {24'b0, last_push},  32'h5A);
        ref_q.push_back(8'h5A);
`else
        // Drop on full: three acked bytes, no pushes, counter at three.
        pc0        = push_cnt;
        force_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            send_byte(b);
        end
        exp_drops  = 3;
        chk("drop_no_push", push_cnt, pc0);
        chk("drop_count",   {24'b0, drop_count}, 32'd3);
        force_full = 1'b0;
        tick();
`endif

        // Reset mid-handshake, inside ACK_WAIT.
        pc0       = push_cnt;
        des_data  = 8'hC3;
        des_ready = 1'b1;
        got       = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            tick();
            if (des_ack === 1'b1) got = 1'b1;
        end
        chk("rmh_ack", {31'b0, got}, 32'd1);
        ref_q.push_back(8'hC3);
        reset = 1'b1;
        #1;
        chk("rmh_ack_drop",  {31'b0, des_ack}, 32'd0);
        chk("rmh_busy_drop", {31'b0, busy},    32'd0);
        des_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        exp_drops = 0;
        tick();
        send_byte(8'hE7);
        ref_q.push_back(8'hE7);
        chk("rmh_push_cnt",  push_cnt,           pc0 + 2);
        chk("rmh_push_data", {24'b0, last_push}, 32'hE7);

        // Randomized push/pop mix against the LIFO reference.
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 1 && ref_q.size() < DEPTH) begin
                b   = 8'($urandom);
                pc0 = push_cnt;
                send_byte(b);
                ref_q.push_back(b);
                chk("rnd_push_cnt",  push_cnt,           pc0 + 1);
                chk("rnd_push_data", {24'b0, last_push}, {24'b0, b});
            end else begin
                do_pop(d, got);
                if (ref_q.size() == 0) begin
                    chk("rnd_pop_empty", {31'b0, got}, 32'd0);
                end else begin
                    chk("rnd_pop_got",  {31'b0, got}, 32'd1);
                    chk("rnd_pop_data", {24'b0, d},   {24'b0, ref_q.pop_back()});
                end
            end
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
        end

        chk("final_drop", {24'b0, drop_count}, exp_drops);
        chk("final_idle", {31'b0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/deser_stack_ctrl.md
Name: deser_stack_ctrl

Overview:
Controller between the 8-bit deserializer and the LIFO stack.
- Crosses the deserializer's data_ready into the clk domain.
- Runs a 4-phase ready/ack handshake with the deserializer and pushes each received byte onto the stack.
- Serves pop requests from a consumer and arbitrates between push and pop for the single stack port.

Parameters:
WIDTH, 8, data word width (matches deserializer output)
SYNC_STAGES, 2, flop stages in the des_ready synchronizer (min 2)
CNT_W, 8, width of drop_count

Ports:
clk  in  1  controller/stack clock
reset  in  1  asynchronous, active-high reset
des_data  in  WIDTH  deserializer output byte; stable while des_ready high
des_ready  in  1  deserializer data_ready, asynchronous to clk
des_ack  out  1  acknowledge to deserializer (level, 4-phase)
stk_push  out  1  one-cycle push strobe to stack
stk_pop  out  1  one-cycle pop strobe to stack
stk_wdata  out  WIDTH  push data
stk_rdata  in  WIDTH  pop data, valid the cycle after stk_pop
stk_full  in  1  stack full
stk_empty  in  1  stack empty
pop_req  in  1  consumer pop request (level, sampled in IDLE)
pop_data  out  WIDTH  popped byte
pop_valid  out  1  one-cycle strobe: pop_data valid
busy  out  1  high whenever state != IDLE
drop_count  out  CNT_W  bytes discarded on full (0 when feature off)

Behaviour:
- Reset: state IDLE; synchronizer, hold register, des_ack, stk_push, stk_pop, stk_wdata, pop_data, pop_valid, busy, drop_count all 0. Reset mid-handshake drops des_ack immediately. The deserializer shares the same reset net.
- All outputs are registered.
- rdy_s is des_ready after SYNC_STAGES flops. des_data is sampled only in CAPTURE, and never directly from the synchronizer path.
- States: IDLE, CAPTURE, PUSH, ACK_WAIT, POP, POP_WAIT.
- IDLE, checked in this priority order:
  - pop_req && !stk_empty -> POP.
  - else rdy_s && !stk_full -> CAPTURE.
  - else stay.
  - Pop has priority over push in the same cycle.
- CAPTURE: hold <= des_data -> PUSH.
- PUSH: stk_push=1 and stk_wdata=hold for exactly this cycle; des_ack <= 1 -> ACK_WAIT.
- ACK_WAIT: keep des_ack=1 until rdy_s==0, then des_ack <= 0 -> IDLE. This completes the 4-phase handshake, so no byte is pushed twice.
- POP: stk_pop=1 for exactly this cycle -> POP_WAIT.
- POP_WAIT: pop_data <= stk_rdata and pop_valid=1 for one cycle -> IDLE.
- Latency from pop_req seen in IDLE: stk_pop at +1, pop_valid at +3.
- Latency from rdy_s rising in IDLE: stk_push at +2.
- pop_req while stk_empty: ignored; pop_valid stays 0.
- rdy_s while stk_full: no ack; the byte stays pending in the deserializer. Pops are still served, and the push proceeds once full clears.
- stk_push and stk_pop are never asserted in the same cycle.
- drop_count saturates at all-ones.

Optional Feature:
Macro DESER_STACK_DROP_ON_FULL_EN.
- Defined: in IDLE, rdy_s && stk_full && no pop pending -> ACK_WAIT directly. des_ack is raised, no push occurs, and drop_count increments (saturating). This keeps the deserializer flowing when the stack is full.
- Undefined: the full-stall behaviour above applies, and drop_count is tied to 0.

Decomposition:
- Package deser_stack_pkg: state_t enum (3-bit, six states) and WIDTH_DEFAULT=8 constant.
- One sub-module: sync_bit (parameter STAGES), a reset-to-0 multi-flop level synchronizer used for des_ready.

Test Plan:
- Push path: reset, then des_data=8'hA5 and raise des_ready. Required: stk_push=1 with stk_wdata=A5 exactly once, SYNC_STAGES+2 cycles after des_ready rises. des_ack rises, and falls after des_ready drops.
- Pop path: stack holds 8'h3C, stk_empty=0, pulse pop_req. Required: stk_pop one cycle; model returns 3C; pop_valid=1 with pop_data=3C at +3.
- Simultaneous: pop_req and rdy_s both high in IDLE. Required: POP sequence first, then CAPTURE/PUSH; never both strobes in one cycle.
- Full stall (macro off): stk_full=1, des_ready high. Required: no des_ack and no stk_push for 20 cycles. Drop stk_full -> push occurs.
- Full drop (macro on): stk_full=1, three bytes delivered. Required: three acks, zero pushes, drop_count=3.
- Reset mid-handshake: assert reset in ACK_WAIT. Required: des_ack=0 and busy=0 immediately; after release, the next byte is pushed normally.
